// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage: FSM states, WB control
// bit positions and default stage parameters.
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  localparam int MEM_WORDS_DEF = 256;
  localparam int LATENCY_DEF   = 2;

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data memory: synchronous write, registered read
// that returns zero when no read is enabled.
module data_memory #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Storage array has no reset so contents survive a pipeline reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0000_0000;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end else begin
      r_rdata <= 32'h0000_0000;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, multi-cycle data memory access with
// stall generation, and the MEM/WB pipeline register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  wbControlExMem,
  input  logic [31:0] aluResult,
  input  logic [31:0] aluZero,
  input  logic [31:0] pc,
  input  logic [31:0] registerData,
  input  logic [4:0]  writeRegister,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  output logic [1:0]  wbControlMemWb,
  output logic [31:0] readDataMemWb,
  output logic [31:0] aluResultMemWb,
  output logic [4:0]  writeRegisterMemWb
);

  localparam int         AW  = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  mem_state_e  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_wb;
  logic [31:0] r_alu;
  logic [4:0]  r_wr;

  logic          w_mem_op;
  logic          w_commit;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_index;
  logic          w_unused;

  assign pcSrc        = branch & aluZero[0];
  assign branchTarget = pc;

  assign w_mem_op = memRead | memWrite;
  assign w_index  = aluResult[AW+1:2];
  assign w_unused = ^{aluZero[31:1], aluResult[31:AW+2], aluResult[1:0]};

  // An instruction completes when it needs no memory, or its wait count is spent
  always_comb begin
    w_commit = 1'b0;
    if (r_state == ST_IDLE) begin
      w_commit = ~w_mem_op | (LAT == 4'd0);
    end else begin
      w_commit = (r_cnt == LAT);
    end
  end

  assign stall = ~reset & ~w_commit;
  assign w_we  = ~reset & w_commit & memWrite;
  assign w_re  = w_commit & memRead;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wb    <= 2'b00;
      r_alu   <= 32'h0000_0000;
      r_wr    <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op && (LAT != 4'd0)) begin
            r_state <= ST_BUSY;
            r_cnt   <= 4'd1;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (r_cnt == LAT) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_state <= ST_BUSY;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase

      // Wait cycles push bubbles into MEM/WB so the stalled op is seen once
      if (w_commit) begin
        r_wb[WB_REG_WRITE]  <= wbControlExMem[WB_REG_WRITE];
        r_wb[WB_MEM_TO_REG] <= wbControlExMem[WB_MEM_TO_REG];
        r_alu               <= aluResult;
        r_wr                <= writeRegister;
      end else begin
        r_wb  <= 2'b00;
        r_alu <= 32'h0000_0000;
        r_wr  <= 5'd0;
      end
    end
  end

  data_memory #(
    .WORDS (MEM_WORDS)
  ) u_dmem (
    .clk   (clock),
    .rst   (reset),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_index),
    .wdata (registerData),
    .rdata (readDataMemWb)
  );

  assign wbControlMemWb     = r_wb;
  assign aluResultMemWb     = r_alu;
  assign writeRegisterMemWb = r_wr;

endmodule
